inst_fetch: RTL and testbench
=============================

// Module: inst_fetch
// PURPOSE
//  Instruction-fetch front end. Supplies the CPU's opcode1/opcode2 stream, replacing bench-driven opcodes.
//  Walks a PC through program ROM and reads two bytes per instruction (rom_data1 = opcode1, rom_data2 = opcode2).
//  Buffers fetched instructions in a small prefetch FIFO.
//  Hands instructions to the CPU decode stage over a valid/ready handshake, with redirect (branch) and HALT support.
// PARAMETERS
//  ADDR_W      8     ROM address / PC width
//  DATA_W      8     opcode byte width
//  FIFO_DEPTH  2     prefetch entries (power of 2, >=2)
//  RESET_PC    8'h00 PC value after reset
// PORTS
//  clk             in   1       rising-edge clock
//  reset           in   1       asynchronous, active-low reset (asserted when 0)
//  rom_address     out  ADDR_W  ROM read address (= pc register, combinational)
//  rom_data1       in   DATA_W  ROM[rom_address], same-cycle combinational data
//  rom_data2       in   DATA_W  ROM[rom_address+1]; ROM returns 8'h00 at address 255
//  opcode1         out  DATA_W  head instruction byte 0; 8'h00 (NOP) when !inst_valid
//  opcode2         out  DATA_W  head instruction byte 1; 8'h00 when !inst_valid
//  inst_pc         out  ADDR_W  address of head instruction; 0 when !inst_valid
//  inst_valid      out  1       FIFO non-empty
//  inst_ready      in   1       CPU accepts head this cycle (pop = valid & ready)
//  redirect_valid  in   1       branch/jump: flush and restart at redirect_addr
//  redirect_addr   in   ADDR_W  new PC; any value, odd allowed
//  halted          out  1       HALT fetched, fetching stopped
// BEHAVIOUR
//  Reset (reset=0, async):
//   - pc=RESET_PC; FIFO empty; halted=0.
//   - Outputs: inst_valid=0, opcode1/2=0, inst_pc=0, rom_address=RESET_PC.
//  Fetch, evaluated every cycle:
//   - push = !halted & !redirect_valid & (!full | pop).
//   - On push, enqueue {rom_data1, rom_data2, pc}, then pc <= pc+2 (mod 2^ADDR_W; 254->0, 255->1).
//   - No push: pc holds.
//  HALT:
//   - A pushed entry with opcode1[7:4]==OP_HALT is enqueued normally; halted <= 1.
//   - While halted: no further pushes, pc holds; queued entries still drain.
//  Handshake:
//   - opcode1/opcode2/inst_pc/inst_valid come straight from the FIFO head registers; no combinational path from inst_ready.
//   - Head holds stable while valid & !ready.
//   - Push and pop in the same cycle are legal when full (count unchanged).
//  Latency:
//   - Entry pushed at edge N is visible on outputs after edge N (valid in cycle N+1).
//   - Sustained throughput 1 instr/cycle with ready held high.
//  Redirect (highest priority, overrides push and pop):
//   - Flush FIFO; pc <= redirect_addr; halted <= 0.
//   - inst_valid=0 in the cycle after the redirect edge.
//   - First new instruction is fetched in that cycle and valid one cycle later (2-cycle redirect bubble).
//   - A pop coinciding with redirect_valid is discarded; the CPU must ignore that head.
//  Reset mid-operation: everything returns to reset values immediately (async), regardless of FIFO/halt state.
// STRUCTURE
//  Package cpu_pkg:
//   - Opcode nibbles: OP_NOP=4'h0, OP_LDI=4'h1, OP_LD=4'h2, OP_ST=4'h3, OP_ALU=4'h8, OP_HALT=4'hF.
//   - typedef struct packed {logic[7:0] opcode1, opcode2, pc;} inst_t.
//  Sub-module inst_fifo:
//   - Synchronous FIFO of inst_t, DEPTH entries, with push/pop/flush.
//   - Outputs full, empty, head; count-based full/empty (no wasted slot).
//  Top level holds the pc/halted registers, push logic and output muxing.
// TESTING
//  1 Reset: reset=0 mid-cycle -> inst_valid=0, opcode1/2=0, rom_address=0; release -> rom_address=0,2,4 on successive cycles.
//  2 Stream, ROM={10 FF, 11 01, 12 F8, 80 13, 33 82}, ready=1:
//    -> opcode pairs appear in that order, inst_pc=0,2,4,6,8, one per cycle after a 1-cycle fill.
//  3 Backpressure: ready=0 for 4 cycles -> FIFO fills (2 entries), rom_address freezes, head held stable;
//    ready=1 -> no loss or duplication.
//  4 Wrap: redirect_addr=8'hFC, ROM[FC..FF]={01 02 03 04} -> pairs (01,02) pc FC, (03,04) pc FE, then pc 00.
//    Redirect to 8'hFF -> opcode2=00.
//  5 Redirect while full and ready=1 -> next cycle inst_valid=0; following cycle head = ROM[redirect_addr]; stale entries never shown.
//  6 HALT: ROM[6]=F0 -> entry at pc 6 delivered, halted=1, rom_address stays 8, no further valid entries.
//    Then redirect_addr=0 -> halted=0 and fetching resumes.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU front-end types: opcode nibbles, the fetched-instruction record
// and a small decode helper used by the fetch unit.
package cpu_pkg;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_LDI  = 4'h1,
    OP_LD   = 4'h2,
    OP_ST   = 4'h3,
    OP_ALU  = 4'h8,
    OP_HALT = 4'hF
  } opcode_e;

  typedef struct packed {
    logic [7:0] opcode1;
    logic [7:0] opcode2;
    logic [7:0] pc;
  } inst_t;

  // An instruction stops the fetch stream when its first byte carries HALT.
  function automatic logic is_halt(input logic [7:0] op1);
    return op1[7:4] == OP_HALT;
  endfunction

endpackage

// File: rtl/inst_fifo.sv
// Prefetch buffer between ROM fetch and decode. Count-based full/empty so
// every slot is usable; flush drops all entries in one cycle. The head is read
// straight out of the storage registers.
module inst_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  push,
  input  logic  pop,
  input  logic  flush,
  input  inst_t din,
  output inst_t head,
  output logic  full,
  output logic  empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  inst_t            mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_p0;
  logic [PTR_W-1:0] rd_ptr_p0;
  logic [CNT_W-1:0] count_p0;
  logic             pop_en;
  logic             wr_en;

  assign full   = (count_p0 == CNT_W'(DEPTH));
  assign empty  = (count_p0 == '0);
  assign pop_en = pop & ~empty & ~flush;
  // A full buffer still accepts a write when the head leaves in the same cycle.
  assign wr_en  = push & ~flush & (~full | pop_en);
  assign head   = mem[rd_ptr_p0];

  // Pointer and occupancy control; flush empties the buffer outright.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_p0 <= '0;
      rd_ptr_p0 <= '0;
      count_p0  <= '0;
    end else if (flush) begin
      wr_ptr_p0 <= '0;
      rd_ptr_p0 <= '0;
      count_p0  <= '0;
    end else begin
      if (wr_en)  wr_ptr_p0 <= wr_ptr_p0 + 1'b1;
      if (pop_en) rd_ptr_p0 <= rd_ptr_p0 + 1'b1;
      case ({wr_en, pop_en})
        2'b10:   count_p0 <= count_p0 + 1'b1;
        2'b01:   count_p0 <= count_p0 - 1'b1;
        default: count_p0 <= count_p0;
      endcase
    end
  end

  // Entry storage; contents are only meaningful while counted as occupied.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_p0] <= din;
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction-fetch front end: walks the PC through program ROM two bytes at
// a time, buffers instructions in a prefetch FIFO and presents the head to
// decode over valid/ready. Redirect flushes and restarts; HALT stops fetching.
module inst_fetch
  import cpu_pkg::*;
#(
  parameter int                ADDR_W     = 8,
  parameter int                DATA_W     = 8,
  parameter int                FIFO_DEPTH = 2,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] rom_address,
  input  logic [DATA_W-1:0] rom_data1,
  input  logic [DATA_W-1:0] rom_data2,
  output logic [DATA_W-1:0] opcode1,
  output logic [DATA_W-1:0] opcode2,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic              halted
);

  logic [ADDR_W-1:0] pc_p0;
  logic              halted_p0;
  logic              push;
  logic              pop;
  logic              full;
  logic              empty;
  inst_t             entry;
  inst_t             head;

  assign rom_address = pc_p0;
  assign halted      = halted_p0;
  assign inst_valid  = ~empty;
  assign pop         = inst_valid & inst_ready;
  assign push        = ~halted_p0 & ~redirect_valid & (~full | pop);

  // Capture the instruction currently addressed by the PC.
  always_comb begin
    entry         = '0;
    entry.opcode1 = rom_data1;
    entry.opcode2 = rom_data2;
    entry.pc      = pc_p0;
  end

  inst_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop & ~redirect_valid),
    .flush (redirect_valid),
    .din   (entry),
    .head  (head),
    .full  (full),
    .empty (empty)
  );

  // PC and halt state; redirect outranks everything and clears a halt.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_p0     <= RESET_PC;
      halted_p0 <= 1'b0;
    end else if (redirect_valid) begin
      pc_p0     <= redirect_addr;
      halted_p0 <= 1'b0;
    end else if (push) begin
      pc_p0 <= pc_p0 + ADDR_W'(2);
      if (is_halt(rom_data1)) halted_p0 <= 1'b1;
    end
  end

  // Decode sees NOP and PC 0 whenever nothing is queued.
  always_comb begin
    opcode1 = '0;
    opcode2 = '0;
    inst_pc = '0;
    if (inst_valid) begin
      opcode1 = head.opcode1;
      opcode2 = head.opcode2;
      inst_pc = head.pc;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Scoreboard bench for inst_fetch: a behavioural ROM feeds the fetch unit and
// each scenario queues the instructions it expects decode to receive.
module tb_inst_fetch;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] rom_address;
  logic [7:0] rom_data1;
  logic [7:0] rom_data2;
  logic [7:0] opcode1;
  logic [7:0] opcode2;
  logic [7:0] inst_pc;
  logic       inst_valid;
  logic       inst_ready = 1'b0;
  logic       redirect_valid = 1'b0;
  logic [7:0] redirect_addr = 8'h00;
  logic       halted;

  logic [7:0]  rom [256];
  logic [23:0] sb [$];
  int          n_checks = 0;
  int          n_fail = 0;
  wire  [23:0] obs = {opcode1, opcode2, inst_pc};

  assign rom_data1 = rom[rom_address];
  assign rom_data2 = (rom_address == 8'hFF) ? 8'h00 : rom[rom_address + 8'd1];

  always #5 clk = ~clk;

  inst_fetch dut (
    .clk            (clk),
    .reset          (reset),
    .rom_address    (rom_address),
    .rom_data1      (rom_data1),
    .rom_data2      (rom_data2),
    .opcode1        (opcode1),
    .opcode2        (opcode2),
    .inst_pc        (inst_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .halted         (halted)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic redirect_to(input logic [7:0] a);
    redirect_valid = 1'b1;
    redirect_addr  = a;
    step();
    redirect_valid = 1'b0;
  endtask

  function automatic logic [23:0] rom_entry(input logic [7:0] pc);
    logic [7:0] b2;
    b2 = (pc == 8'hFF) ? 8'h00 : rom[pc + 8'd1];
    return {rom[pc], b2, pc};
  endfunction

  task automatic test_reset();
    logic [23:0] exp;
    reset = 1'b0; inst_ready = 1'b0;
    #3;
    n_checks++;
    if ({inst_valid, halted, obs, rom_address} !== 34'h0) begin
      n_fail++; $display("FAIL reset_outputs: got valid=%b halted=%b ops=%h addr=%h required all zero", inst_valid, halted, obs, rom_address);
    end
    step();
    reset = 1'b1;
    n_checks++;
    if (rom_address !== 8'h00) begin
      n_fail++; $display("FAIL reset_addr0: got %h required 00", rom_address);
    end
    step();
    n_checks++;
    if (rom_address !== 8'h02) begin
      n_fail++; $display("FAIL reset_addr1: got %h required 02", rom_address);
    end
    step();
    exp = rom_entry(8'h00);
    n_checks++;
    if ({rom_address, inst_valid, obs} !== {8'h04, 1'b1, exp}) begin
      n_fail++; $display("FAIL reset_addr2: got addr=%h valid=%b head=%h required addr=04 valid=1 head=%h", rom_address, inst_valid, obs, exp);
    end
    step();
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if ({inst_valid, halted, obs, rom_address} !== 34'h0) begin
      n_fail++; $display("FAIL reset_async: got valid=%b halted=%b ops=%h addr=%h required all zero", inst_valid, halted, obs, rom_address);
    end
  endtask

  task automatic test_stream();
    logic [23:0] exp;
    int first, last;
    first = -1; last = -1;
    for (int k = 0; k < 5; k++) sb.push_back(rom_entry(8'(2 * k)));
    inst_ready = 1'b1;
    step();
    reset = 1'b1;
    n_checks++;
    if (inst_valid !== 1'b0) begin
      n_fail++; $display("FAIL stream_fill: got valid=%b required 0", inst_valid);
    end
    for (int c = 1; c <= 20 && sb.size() > 0; c++) begin
      step();
      if (inst_valid) begin
        exp = sb.pop_front();
        n_checks++;
        if (obs !== exp || (last >= 0 && c != last + 1)) begin
          n_fail++; $display("FAIL stream_head: got %h at cycle %0d required %h at cycle %0d", obs, c, exp, last + 1);
        end
        if (first < 0) first = c;
        last = c;
      end
    end
    n_checks++;
    if (sb.size() != 0 || first != 1) begin
      n_fail++; $display("FAIL stream_timing: got first=%0d left=%0d required first=1 left=0", first, sb.size());
    end
    sb.delete();
  endtask

  task automatic test_backpressure();
    logic [23:0] exp;
    inst_ready = 1'b0;
    redirect_to(8'h00);
    for (int k = 0; k < 5; k++) sb.push_back(rom_entry(8'(2 * k)));
    exp = rom_entry(8'h00);
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++;
      if ({inst_valid, obs} !== {1'b1, exp} || (i >= 1 && rom_address !== 8'h04)) begin
        n_fail++; $display("FAIL bp_hold%0d: got valid=%b head=%h addr=%h required valid=1 head=%h addr=04", i, inst_valid, obs, rom_address, exp);
      end
    end
    inst_ready = 1'b1;
    for (int c = 0; c < 20 && sb.size() > 0; c++) begin
      if (inst_valid) begin
        exp = sb.pop_front();
        n_checks++;
        if (obs !== exp) begin
          n_fail++; $display("FAIL bp_drain: got %h required %h", obs, exp);
        end
      end
      step();
    end
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++; $display("FAIL bp_timeout: got %0d left required 0", sb.size());
    end
    sb.delete();
  endtask

  task automatic test_wrap();
    logic [23:0] exp;
    rom[8'hFC] = 8'h01; rom[8'hFD] = 8'h02; rom[8'hFE] = 8'h03; rom[8'hFF] = 8'h04;
    sb.push_back(24'h0102FC);
    sb.push_back(24'h0304FE);
    sb.push_back({rom[0], rom[1], 8'h00});
    inst_ready = 1'b1;
    redirect_to(8'hFC);
    n_checks++;
    if (inst_valid !== 1'b0) begin
      n_fail++; $display("FAIL wrap_bubble: got valid=%b required 0", inst_valid);
    end
    for (int c = 0; c < 20 && sb.size() > 0; c++) begin
      if (inst_valid) begin
        exp = sb.pop_front();
        n_checks++;
        if (obs !== exp) begin
          n_fail++; $display("FAIL wrap_head: got %h required %h", obs, exp);
        end
      end
      step();
    end
    sb.push_back(24'h0400FF);
    redirect_to(8'hFF);
    for (int c = 0; c < 20 && sb.size() > 0; c++) begin
      if (inst_valid) begin
        exp = sb.pop_front();
        n_checks++;
        if (obs !== exp) begin
          n_fail++; $display("FAIL wrap_ff: got %h required %h", obs, exp);
        end
      end
      step();
    end
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++; $display("FAIL wrap_timeout: got %0d left required 0", sb.size());
    end
    sb.delete();
  endtask

  task automatic test_redirect_full();
    logic [23:0] exp;
    inst_ready = 1'b0;
    redirect_to(8'h20);
    step(); step(); step();
    rom[8'h40] = 8'hA1; rom[8'h41] = 8'hA2; rom[8'h42] = 8'hA3; rom[8'h43] = 8'hA4;
    sb.push_back(24'hA1A240);
    sb.push_back(24'hA3A442);
    inst_ready = 1'b1;
    redirect_to(8'h40);
    n_checks++;
    if (inst_valid !== 1'b0) begin
      n_fail++; $display("FAIL redir_bubble: got valid=%b head=%h required valid=0", inst_valid, obs);
    end
    step();
    n_checks++;
    if ({inst_valid, obs} !== {1'b1, 24'hA1A240}) begin
      n_fail++; $display("FAIL redir_first: got valid=%b head=%h required valid=1 head=a1a240", inst_valid, obs);
    end
    for (int c = 0; c < 20 && sb.size() > 0; c++) begin
      if (inst_valid) begin
        exp = sb.pop_front();
        n_checks++;
        if (obs !== exp) begin
          n_fail++; $display("FAIL redir_head: got %h required %h", obs, exp);
        end
      end
      step();
    end
    sb.delete();
  endtask

  task automatic test_halt();
    logic [23:0] exp;
    rom[6] = 8'hF0;
    for (int k = 0; k < 4; k++) sb.push_back(rom_entry(8'(2 * k)));
    inst_ready = 1'b1;
    redirect_to(8'h00);
    for (int c = 0; c < 20 && sb.size() > 0; c++) begin
      if (inst_valid) begin
        exp = sb.pop_front();
        n_checks++;
        if (obs !== exp) begin
          n_fail++; $display("FAIL halt_head: got %h required %h", obs, exp);
        end
      end
      step();
    end
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++; $display("FAIL halt_timeout: got %0d left required 0", sb.size());
    end
    sb.delete();
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if ({inst_valid, halted, rom_address} !== {1'b0, 1'b1, 8'h08}) begin
        n_fail++; $display("FAIL halt_stop%0d: got valid=%b halted=%b addr=%h required valid=0 halted=1 addr=08", i, inst_valid, halted, rom_address);
      end
      step();
    end
    exp = rom_entry(8'h00);
    redirect_to(8'h00);
    n_checks++;
    if ({halted, inst_valid} !== 2'b00) begin
      n_fail++; $display("FAIL halt_clear: got halted=%b valid=%b required 0 0", halted, inst_valid);
    end
    step();
    n_checks++;
    if ({inst_valid, obs} !== {1'b1, exp}) begin
      n_fail++; $display("FAIL halt_resume: got valid=%b head=%h required valid=1 head=%h", inst_valid, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    rom[0] = 8'h10; rom[1] = 8'hFF; rom[2] = 8'h11; rom[3] = 8'h01; rom[4] = 8'h12;
    rom[5] = 8'hF8; rom[6] = 8'h80; rom[7] = 8'h13; rom[8] = 8'h33; rom[9] = 8'h82;
    test_reset();
    test_stream();
    test_backpressure();
    test_wrap();
    test_redirect_full();
    test_halt();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
